// File: rtl/block_hit_pipeline_pkg.sv
// ---------------------------------------------------------------------------
// block_hit_pipeline_pkg
//
// Purpose: shared constants for the obstacle hit pipeline. Holds the default
// coordinate/shape widths, the obstacle width, the legacy shape codes, and
// the default segment table for the eleven legacy shapes. The game-logic
// loader uses this table when it fills the runtime shape table.
//
// Ports: none (package).
// ---------------------------------------------------------------------------
package block_hit_pipeline_pkg;

  localparam int DEFAULT_COORD_W     = 10;
  localparam int DEFAULT_SHAPE_W     = 4;
  localparam int DEFAULT_NUM_BLOCKS  = 4;
  localparam int DEFAULT_NUM_SHAPES  = 11;
  localparam int DEFAULT_MAX_SEGS    = 3;
  localparam int DEFAULT_BLOCK_WIDTH = 40;

  // Legacy obstacle shapes inherited from the single-block renderer
  typedef enum logic [DEFAULT_SHAPE_W-1:0] {
    SHAPE_NONE      = 4'd0,
    SHAPE_FULL      = 4'd1,
    SHAPE_TOP_SHORT = 4'd2,
    SHAPE_TOP_TALL  = 4'd3,
    SHAPE_BOT_SHORT = 4'd4,
    SHAPE_BOT_TALL  = 4'd5,
    SHAPE_GAP_HIGH  = 4'd6,
    SHAPE_GAP_MID   = 4'd7,
    SHAPE_GAP_LOW   = 4'd8,
    SHAPE_TRIPLE    = 4'd9,
    SHAPE_FLOAT     = 4'd10
  } shape_code_e;

  // One vertical segment: top row and height (height 0 = unused)
  typedef struct packed {
    logic [DEFAULT_COORD_W-1:0] top;
    logic [DEFAULT_COORD_W-1:0] len;
  } seg_t;

  // Default segment table for the legacy shapes on a 480-line screen
  function automatic seg_t default_seg(input shape_code_e shape, input int seg);
    seg_t r;
    r = '0;
    case (shape)
      SHAPE_FULL:      if (seg == 0) r = '{top: 10'd0,   len: 10'd480};
      SHAPE_TOP_SHORT: if (seg == 0) r = '{top: 10'd0,   len: 10'd120};
      SHAPE_TOP_TALL:  if (seg == 0) r = '{top: 10'd0,   len: 10'd280};
      SHAPE_BOT_SHORT: if (seg == 0) r = '{top: 10'd360, len: 10'd120};
      SHAPE_BOT_TALL:  if (seg == 0) r = '{top: 10'd200, len: 10'd280};
      SHAPE_GAP_HIGH: begin
        if (seg == 0) r = '{top: 10'd0,   len: 10'd40};
        if (seg == 1) r = '{top: 10'd160, len: 10'd320};
      end
      SHAPE_GAP_MID: begin
        if (seg == 0) r = '{top: 10'd0,   len: 10'd180};
        if (seg == 1) r = '{top: 10'd300, len: 10'd180};
      end
      SHAPE_GAP_LOW: begin
        if (seg == 0) r = '{top: 10'd0,   len: 10'd320};
        if (seg == 1) r = '{top: 10'd440, len: 10'd40};
      end
      SHAPE_TRIPLE: begin
        if (seg == 0) r = '{top: 10'd0,   len: 10'd100};
        if (seg == 1) r = '{top: 10'd190, len: 10'd100};
        if (seg == 2) r = '{top: 10'd380, len: 10'd100};
      end
      SHAPE_FLOAT:     if (seg == 0) r = '{top: 10'd200, len: 10'd80};
      default:         r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/block_hit_pipeline_channel.sv
// ---------------------------------------------------------------------------
// block_channel_eval
//
// Purpose: stage-1 work for one obstacle channel. Tests the scan X against
// the channel's horizontal span and looks up the channel's shape segments
// in the flattened shape table. Purely combinational; the top registers the
// results.
//
// Configuration: define BLOCK_WRAP_EN to make the X span test modulo
// 2^COORD_W so a block near the right edge wraps to the left edge.
//
// Ports:
//   x            scan X
//   block_en     channel enable
//   block_x      channel left edge
//   block_shape  channel shape code
//   tbl_y_flat   shape table segment tops, entry (k,s) at (k*MAX_SEGS+s)*COORD_W
//   tbl_len_flat shape table segment heights, same layout
//   x_hit        X inside the enabled channel with a valid shape
//   seg_y        this shape's segment tops, segment s at s*COORD_W
//   seg_len      this shape's segment heights
// ---------------------------------------------------------------------------
module block_channel_eval
  import block_hit_pipeline_pkg::*;
#(
  parameter int COORD_W     = DEFAULT_COORD_W,
  parameter int SHAPE_W     = DEFAULT_SHAPE_W,
  parameter int NUM_SHAPES  = DEFAULT_NUM_SHAPES,
  parameter int MAX_SEGS    = DEFAULT_MAX_SEGS,
  parameter int BLOCK_WIDTH = DEFAULT_BLOCK_WIDTH
) (
  input  logic [COORD_W-1:0]                     x,
  input  logic                                   block_en,
  input  logic [COORD_W-1:0]                     block_x,
  input  logic [SHAPE_W-1:0]                     block_shape,
  input  logic [NUM_SHAPES*MAX_SEGS*COORD_W-1:0] tbl_y_flat,
  input  logic [NUM_SHAPES*MAX_SEGS*COORD_W-1:0] tbl_len_flat,
  output logic                                   x_hit,
  output logic [MAX_SEGS*COORD_W-1:0]            seg_y,
  output logic [MAX_SEGS*COORD_W-1:0]            seg_len
);

  localparam logic [COORD_W:0] WIDTH_EXT   = (COORD_W+1)'(BLOCK_WIDTH);
  localparam logic [SHAPE_W:0] SHAPE_LIMIT = (SHAPE_W+1)'(NUM_SHAPES);

  logic shape_ok;
  logic in_x;

  assign shape_ok = ({1'b0, block_shape} < SHAPE_LIMIT);

`ifdef BLOCK_WRAP_EN
  // Offset from the left edge wraps at the screen width
  logic [COORD_W-1:0] x_off;
  assign x_off = x - block_x;
  assign in_x  = ({1'b0, x_off} < WIDTH_EXT);
`else
  // Right edge computed one bit wider so it never wraps
  assign in_x = ({1'b0, x} >= {1'b0, block_x}) &&
                ({1'b0, x} < ({1'b0, block_x} + WIDTH_EXT));
`endif

  assign x_hit = block_en && shape_ok && in_x;

  // Select the shape's segments; out-of-range codes select nothing (all zero)
  always_comb begin
    seg_y   = '0;
    seg_len = '0;
    for (int s = 0; s < MAX_SEGS; s++) begin
      for (int k = 0; k < NUM_SHAPES; k++) begin
        if (block_shape == SHAPE_W'(k)) begin
          seg_y[s*COORD_W +: COORD_W]   = tbl_y_flat[(k*MAX_SEGS+s)*COORD_W +: COORD_W];
          seg_len[s*COORD_W +: COORD_W] = tbl_len_flat[(k*MAX_SEGS+s)*COORD_W +: COORD_W];
        end
      end
    end
  end

endmodule

// File: rtl/block_hit_pipeline.sv
// ---------------------------------------------------------------------------
// block_hit_pipeline
//
// Purpose: evaluates NUM_BLOCKS obstacle columns against the current scan
// pixel in a two-stage pipeline (fixed latency 2, one pixel per cycle).
// Shapes come from a runtime-loaded table of MAX_SEGS vertical segments per
// shape. Also keeps a frame-sticky flag set when a player-sprite pixel lands
// inside any block.
//
// Configuration: define BLOCK_WRAP_EN to make the horizontal block span wrap
// modulo 2^COORD_W (handled in block_channel_eval).
//
// Ports:
//   CLK, RST      clock, synchronous active-high reset
//   PIX_VALID     X/Y/PLAYER_MASK valid this cycle
//   X, Y          scan coordinates
//   PLAYER_MASK   pixel belongs to the player sprite
//   FRAME_START   one-cycle pulse that clears HIT
//   BLOCK_EN      per-channel enable
//   BLOCK_X       per-channel left edge, channel i at [i*COORD_W +: COORD_W]
//   BLOCK_SHAPE   per-channel shape code, channel i at [i*SHAPE_W +: SHAPE_W]
//   TBL_*         shape table write port (TBL_LEN 0 disables a segment)
//   OUT_VALID     result valid
//   IN_BLOCK      pixel inside any enabled block (holds when not valid)
//   BLOCK_IDX     lowest matching channel, 0 on a miss (holds when not valid)
//   HIT           sticky player/block overlap for this frame
// ---------------------------------------------------------------------------
module block_hit_pipeline
  import block_hit_pipeline_pkg::*;
#(
  parameter int COORD_W     = DEFAULT_COORD_W,
  parameter int NUM_BLOCKS  = DEFAULT_NUM_BLOCKS,
  parameter int SHAPE_W     = DEFAULT_SHAPE_W,
  parameter int NUM_SHAPES  = DEFAULT_NUM_SHAPES,
  parameter int MAX_SEGS    = DEFAULT_MAX_SEGS,
  parameter int BLOCK_WIDTH = DEFAULT_BLOCK_WIDTH,
  localparam int SEG_W      = (MAX_SEGS > 1) ? $clog2(MAX_SEGS) : 1,
  localparam int IDX_W      = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          PIX_VALID,
  input  logic [COORD_W-1:0]            X,
  input  logic [COORD_W-1:0]            Y,
  input  logic                          PLAYER_MASK,
  input  logic                          FRAME_START,
  input  logic [NUM_BLOCKS-1:0]         BLOCK_EN,
  input  logic [NUM_BLOCKS*COORD_W-1:0] BLOCK_X,
  input  logic [NUM_BLOCKS*SHAPE_W-1:0] BLOCK_SHAPE,
  input  logic                          TBL_WE,
  input  logic [SHAPE_W-1:0]            TBL_SHAPE,
  input  logic [SEG_W-1:0]              TBL_SEG,
  input  logic [COORD_W-1:0]            TBL_Y,
  input  logic [COORD_W-1:0]            TBL_LEN,
  output logic                          OUT_VALID,
  output logic                          IN_BLOCK,
  output logic [IDX_W-1:0]              BLOCK_IDX,
  output logic                          HIT
);

  localparam int TBL_BITS = NUM_SHAPES * MAX_SEGS * COORD_W;

  logic [TBL_BITS-1:0] tbl_y_flat;
  logic [TBL_BITS-1:0] tbl_len_flat;

  logic [NUM_BLOCKS-1:0]         x_hit_c;
  logic [MAX_SEGS*COORD_W-1:0]   seg_y_c   [NUM_BLOCKS];
  logic [MAX_SEGS*COORD_W-1:0]   seg_len_c [NUM_BLOCKS];

  logic                          valid_s1;
  logic [COORD_W-1:0]            y_s1;
  logic                          mask_s1;
  logic [NUM_BLOCKS-1:0]         x_hit_s1;
  logic [MAX_SEGS*COORD_W-1:0]   seg_y_s1   [NUM_BLOCKS];
  logic [MAX_SEGS*COORD_W-1:0]   seg_len_s1 [NUM_BLOCKS];

  logic [NUM_BLOCKS-1:0]         ch_hit;
  logic                          in_block_comb;
  logic [IDX_W-1:0]              idx_comb;

  // Shape table. Entries and segments beyond the table match no slot in the
  // loop, so out-of-range writes fall through harmlessly. A pixel sampled on
  // the write edge reads the pre-write contents.
  always_ff @(posedge CLK) begin
    if (RST) begin
      tbl_y_flat   <= '0;
      tbl_len_flat <= '0;
    end else if (TBL_WE) begin
      for (int k = 0; k < NUM_SHAPES; k++) begin
        for (int s = 0; s < MAX_SEGS; s++) begin
          if (TBL_SHAPE == SHAPE_W'(k) && TBL_SEG == SEG_W'(s)) begin
            tbl_y_flat[(k*MAX_SEGS+s)*COORD_W +: COORD_W]   <= TBL_Y;
            tbl_len_flat[(k*MAX_SEGS+s)*COORD_W +: COORD_W] <= TBL_LEN;
          end
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_BLOCKS; i++) begin : g_ch
    block_channel_eval #(
      .COORD_W     (COORD_W),
      .SHAPE_W     (SHAPE_W),
      .NUM_SHAPES  (NUM_SHAPES),
      .MAX_SEGS    (MAX_SEGS),
      .BLOCK_WIDTH (BLOCK_WIDTH)
    ) u_eval (
      .x            (X),
      .block_en     (BLOCK_EN[i]),
      .block_x      (BLOCK_X[i*COORD_W +: COORD_W]),
      .block_shape  (BLOCK_SHAPE[i*SHAPE_W +: SHAPE_W]),
      .tbl_y_flat   (tbl_y_flat),
      .tbl_len_flat (tbl_len_flat),
      .x_hit        (x_hit_c[i]),
      .seg_y        (seg_y_c[i]),
      .seg_len      (seg_len_c[i])
    );
  end

  // Stage 1: capture the pixel plus each channel's X result and segments
  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_s1 <= 1'b0;
      y_s1     <= '0;
      mask_s1  <= 1'b0;
      x_hit_s1 <= '0;
      for (int i = 0; i < NUM_BLOCKS; i++) begin
        seg_y_s1[i]   <= '0;
        seg_len_s1[i] <= '0;
      end
    end else begin
      valid_s1 <= PIX_VALID;
      y_s1     <= Y;
      mask_s1  <= PLAYER_MASK;
      x_hit_s1 <= x_hit_c;
      for (int i = 0; i < NUM_BLOCKS; i++) begin
        seg_y_s1[i]   <= seg_y_c[i];
        seg_len_s1[i] <= seg_len_c[i];
      end
    end
  end

  // Stage 2 Y test: segment end is summed one bit wider so it never wraps
  always_comb begin
    ch_hit = '0;
    for (int i = 0; i < NUM_BLOCKS; i++) begin
      for (int s = 0; s < MAX_SEGS; s++) begin
        if (x_hit_s1[i]
            && (seg_len_s1[i][s*COORD_W +: COORD_W] != '0)
            && (y_s1 >= seg_y_s1[i][s*COORD_W +: COORD_W])
            && ({1'b0, y_s1} < ({1'b0, seg_y_s1[i][s*COORD_W +: COORD_W]} +
                                {1'b0, seg_len_s1[i][s*COORD_W +: COORD_W]}))) begin
          ch_hit[i] = 1'b1;
        end
      end
    end
  end

  // Lowest-index channel wins; scan downward so the last write is the lowest
  always_comb begin
    idx_comb = '0;
    for (int i = NUM_BLOCKS - 1; i >= 0; i--) begin
      if (ch_hit[i]) idx_comb = IDX_W'(i);
    end
  end

  assign in_block_comb = |ch_hit;

  // Output stage and sticky HIT; a set on the FRAME_START cycle wins the clear
  always_ff @(posedge CLK) begin
    if (RST) begin
      OUT_VALID <= 1'b0;
      IN_BLOCK  <= 1'b0;
      BLOCK_IDX <= '0;
      HIT       <= 1'b0;
    end else begin
      OUT_VALID <= valid_s1;
      if (valid_s1) begin
        IN_BLOCK  <= in_block_comb;
        BLOCK_IDX <= idx_comb;
      end
      HIT <= (HIT && !FRAME_START) || (valid_s1 && in_block_comb && mask_s1);
    end
  end

endmodule

// File: tb/tb_block_hit_pipeline.sv
// ---------------------------------------------------------------------------
// tb_block_hit_pipeline
//
// Purpose: directed self-checking bench for block_hit_pipeline. Inputs are
// driven on the falling edge and outputs sampled on the falling edge, so a
// pixel driven at one falling edge shows its result two falling edges later.
// Expectations for the wrap case follow BLOCK_WRAP_EN.
// ---------------------------------------------------------------------------
module tb_block_hit_pipeline;

  localparam int CW = 10;
  localparam int NB = 4;
  localparam int SW = 4;

  logic             CLK = 1'b0;
  logic             RST;
  logic             PIX_VALID;
  logic [CW-1:0]    X;
  logic [CW-1:0]    Y;
  logic             PLAYER_MASK;
  logic             FRAME_START;
  logic [NB-1:0]    BLOCK_EN;
  logic [NB*CW-1:0] BLOCK_X;
  logic [NB*SW-1:0] BLOCK_SHAPE;
  logic             TBL_WE;
  logic [SW-1:0]    TBL_SHAPE;
  logic [1:0]       TBL_SEG;
  logic [CW-1:0]    TBL_Y;
  logic [CW-1:0]    TBL_LEN;
  logic             OUT_VALID;
  logic             IN_BLOCK;
  logic [1:0]       BLOCK_IDX;
  logic             HIT;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  block_hit_pipeline dut (
    .CLK         (CLK),
    .RST         (RST),
    .PIX_VALID   (PIX_VALID),
    .X           (X),
    .Y           (Y),
    .PLAYER_MASK (PLAYER_MASK),
    .FRAME_START (FRAME_START),
    .BLOCK_EN    (BLOCK_EN),
    .BLOCK_X     (BLOCK_X),
    .BLOCK_SHAPE (BLOCK_SHAPE),
    .TBL_WE      (TBL_WE),
    .TBL_SHAPE   (TBL_SHAPE),
    .TBL_SEG     (TBL_SEG),
    .TBL_Y       (TBL_Y),
    .TBL_LEN     (TBL_LEN),
    .OUT_VALID   (OUT_VALID),
    .IN_BLOCK    (IN_BLOCK),
    .BLOCK_IDX   (BLOCK_IDX),
    .HIT         (HIT)
  );

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic set_ch(input int ch, input logic en, input logic [CW-1:0] bx,
                        input logic [SW-1:0] shape);
    BLOCK_EN[ch]            = en;
    BLOCK_X[ch*CW +: CW]    = bx;
    BLOCK_SHAPE[ch*SW +: SW] = shape;
  endtask

  task automatic drive_pixel(input logic [CW-1:0] px, input logic [CW-1:0] py,
                             input logic mask);
    PIX_VALID   = 1'b1;
    X           = px;
    Y           = py;
    PLAYER_MASK = mask;
  endtask

  task automatic idle();
    PIX_VALID   = 1'b0;
    PLAYER_MASK = 1'b0;
  endtask

  task automatic write_seg(input logic [SW-1:0] shape, input logic [1:0] seg,
                           input logic [CW-1:0] top, input logic [CW-1:0] len);
    TBL_WE    = 1'b1;
    TBL_SHAPE = shape;
    TBL_SEG   = seg;
    TBL_Y     = top;
    TBL_LEN   = len;
    tick();
    TBL_WE    = 1'b0;
  endtask

  // Reset values, then an empty table gives a valid miss at latency 2
  task automatic test_reset();
    RST = 1'b1;
    tick();
    tick();
    checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b want 0", OUT_VALID); end
    checks++; if (IN_BLOCK !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_block: got %b want 0", IN_BLOCK); end
    checks++; if (BLOCK_IDX !== 2'd0) begin errors++; $display("[TB] FAIL reset_block_idx: got %0d want 0", BLOCK_IDX); end
    checks++; if (HIT !== 1'b0) begin errors++; $display("[TB] FAIL reset_hit: got %b want 0", HIT); end
    RST = 1'b0;
    set_ch(0, 1'b1, 10'd100, 4'd1);
    drive_pixel(10'd110, 10'd50, 1'b0);
    tick();
    idle();
    checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("[TB] FAIL empty_latency1: OUT_VALID got %b want 0", OUT_VALID); end
    tick();
    checks++; if (OUT_VALID !== 1'b1) begin errors++; $display("[TB] FAIL empty_latency2: OUT_VALID got %b want 1", OUT_VALID); end
    checks++; if (IN_BLOCK !== 1'b0) begin errors++; $display("[TB] FAIL empty_in_block: got %b want 0", IN_BLOCK); end
    checks++; if (HIT !== 1'b0) begin errors++; $display("[TB] FAIL empty_hit: got %b want 0", HIT); end
  endtask

  // X and Y boundaries of a block streamed back to back
  task automatic test_x_edges();
    logic [CW-1:0] px [6] = '{10'd99, 10'd100, 10'd139, 10'd140, 10'd120, 10'd120};
    logic [CW-1:0] py [6] = '{10'd60, 10'd60, 10'd60, 10'd60, 10'd119, 10'd120};
    logic          ex [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    write_seg(4'd1, 2'd0, 10'd0, 10'd120);
    set_ch(0, 1'b1, 10'd100, 4'd1);
    for (int k = 0; k < 8; k++) begin
      if (k >= 2) begin
        checks++;
        if (OUT_VALID !== 1'b1 || IN_BLOCK !== ex[k-2] || BLOCK_IDX !== 2'd0) begin
          errors++;
          $display("[TB] FAIL edge_%0d: valid/in/idx got %b/%b/%0d want 1/%b/0",
                   k - 2, OUT_VALID, IN_BLOCK, BLOCK_IDX, ex[k-2]);
        end
      end
      if (k < 6) drive_pixel(px[k], py[k], 1'b0);
      else       idle();
      tick();
    end
  endtask

  // Overlapping channels: lowest index wins; outputs hold over a bubble
  task automatic test_priority();
    set_ch(0, 1'b1, 10'd180, 4'd1);
    set_ch(2, 1'b1, 10'd190, 4'd1);
    drive_pixel(10'd200, 10'd10, 1'b0);
    tick(); idle(); tick();
    checks++; if (IN_BLOCK !== 1'b1 || BLOCK_IDX !== 2'd0) begin errors++; $display("[TB] FAIL prio_both: in/idx got %b/%0d want 1/0", IN_BLOCK, BLOCK_IDX); end
    set_ch(0, 1'b0, 10'd180, 4'd1);
    drive_pixel(10'd200, 10'd10, 1'b0);
    tick(); idle(); tick();
    checks++; if (IN_BLOCK !== 1'b1 || BLOCK_IDX !== 2'd2) begin errors++; $display("[TB] FAIL prio_ch2: in/idx got %b/%0d want 1/2", IN_BLOCK, BLOCK_IDX); end
    tick();
    checks++; if (OUT_VALID !== 1'b0 || IN_BLOCK !== 1'b1 || BLOCK_IDX !== 2'd2) begin errors++; $display("[TB] FAIL prio_hold: valid/in/idx got %b/%b/%0d want 0/1/2", OUT_VALID, IN_BLOCK, BLOCK_IDX); end
    drive_pixel(10'd300, 10'd10, 1'b0);
    tick(); idle(); tick();
    checks++; if (IN_BLOCK !== 1'b0 || BLOCK_IDX !== 2'd0) begin errors++; $display("[TB] FAIL prio_miss: in/idx got %b/%0d want 0/0", IN_BLOCK, BLOCK_IDX); end
    set_ch(2, 1'b0, 10'd190, 4'd1);
  endtask

  // A write on the same edge as a pixel is seen only by the next pixel
  task automatic test_table_write();
    set_ch(0, 1'b1, 10'd100, 4'd1);
    drive_pixel(10'd120, 10'd60, 1'b0);
    TBL_WE = 1'b1; TBL_SHAPE = 4'd1; TBL_SEG = 2'd0; TBL_Y = 10'd0; TBL_LEN = 10'd0;
    tick();
    TBL_WE = 1'b0;
    drive_pixel(10'd121, 10'd60, 1'b0);
    tick();
    idle();
    checks++; if (OUT_VALID !== 1'b1 || IN_BLOCK !== 1'b1) begin errors++; $display("[TB] FAIL write_old: valid/in got %b/%b want 1/1", OUT_VALID, IN_BLOCK); end
    tick();
    checks++; if (OUT_VALID !== 1'b1 || IN_BLOCK !== 1'b0) begin errors++; $display("[TB] FAIL write_new: valid/in got %b/%b want 1/0", OUT_VALID, IN_BLOCK); end
    write_seg(4'd1, 2'd0, 10'd0, 10'd120);
  endtask

  // Multi-segment shape boundaries and an out-of-range shape code
  task automatic test_segments();
    logic [CW-1:0] py [6] = '{10'd9, 10'd10, 10'd14, 10'd15, 10'd100, 10'd101};
    logic          ex [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    write_seg(4'd2, 2'd0, 10'd10, 10'd5);
    write_seg(4'd2, 2'd2, 10'd100, 10'd1);
    set_ch(0, 1'b1, 10'd100, 4'd2);
    for (int k = 0; k < 8; k++) begin
      if (k >= 2) begin
        checks++;
        if (OUT_VALID !== 1'b1 || IN_BLOCK !== ex[k-2]) begin
          errors++;
          $display("[TB] FAIL seg_%0d: valid/in got %b/%b want 1/%b", k - 2, OUT_VALID, IN_BLOCK, ex[k-2]);
        end
      end
      if (k < 6) drive_pixel(10'd120, py[k], 1'b0);
      else       idle();
      tick();
    end
    write_seg(4'd11, 2'd0, 10'd0, 10'd120);
    set_ch(0, 1'b1, 10'd100, 4'd11);
    drive_pixel(10'd120, 10'd60, 1'b0);
    tick(); idle(); tick();
    checks++; if (OUT_VALID !== 1'b1 || IN_BLOCK !== 1'b0) begin errors++; $display("[TB] FAIL bad_shape: valid/in got %b/%b want 1/0", OUT_VALID, IN_BLOCK); end
    set_ch(0, 1'b1, 10'd100, 4'd1);
  endtask

  // Sticky HIT: needs both mask and block; clear; set beats clear
  task automatic test_hit();
    drive_pixel(10'd120, 10'd60, 1'b0);
    tick(); idle(); tick();
    checks++; if (HIT !== 1'b0) begin errors++; $display("[TB] FAIL hit_nomask: got %b want 0", HIT); end
    drive_pixel(10'd300, 10'd60, 1'b1);
    tick(); idle(); tick();
    checks++; if (HIT !== 1'b0) begin errors++; $display("[TB] FAIL hit_noblock: got %b want 0", HIT); end
    drive_pixel(10'd120, 10'd60, 1'b1);
    tick(); idle();
    checks++; if (HIT !== 1'b0) begin errors++; $display("[TB] FAIL hit_early: got %b want 0", HIT); end
    tick();
    checks++; if (HIT !== 1'b1) begin errors++; $display("[TB] FAIL hit_set: got %b want 1", HIT); end
    tick(); tick();
    checks++; if (HIT !== 1'b1) begin errors++; $display("[TB] FAIL hit_sticky: got %b want 1", HIT); end
    FRAME_START = 1'b1;
    tick();
    FRAME_START = 1'b0;
    checks++; if (HIT !== 1'b0) begin errors++; $display("[TB] FAIL hit_clear: got %b want 0", HIT); end
    drive_pixel(10'd120, 10'd60, 1'b1);
    tick();
    idle();
    FRAME_START = 1'b1;
    tick();
    FRAME_START = 1'b0;
    checks++; if (HIT !== 1'b1) begin errors++; $display("[TB] FAIL hit_set_wins: got %b want 1", HIT); end
    FRAME_START = 1'b1;
    tick();
    FRAME_START = 1'b0;
  endtask

  // Block near the right edge: wraps only when BLOCK_WRAP_EN is defined
  task automatic test_wrap();
    logic [CW-1:0] px [5] = '{10'd5, 10'd1015, 10'd29, 10'd1009, 10'd1023};
`ifdef BLOCK_WRAP_EN
    logic          ex [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
`else
    logic          ex [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
`endif
    set_ch(0, 1'b1, 10'd1010, 4'd1);
    for (int k = 0; k < 7; k++) begin
      if (k >= 2) begin
        checks++;
        if (OUT_VALID !== 1'b1 || IN_BLOCK !== ex[k-2]) begin
          errors++;
          $display("[TB] FAIL wrap_%0d: valid/in got %b/%b want 1/%b", k - 2, OUT_VALID, IN_BLOCK, ex[k-2]);
        end
      end
      if (k < 5) drive_pixel(px[k], 10'd60, 1'b0);
      else       idle();
      tick();
    end
    set_ch(0, 1'b1, 10'd100, 4'd1);
  endtask

  // Reset with pixels in flight drops them and empties the table
  task automatic test_reset_midstream();
    drive_pixel(10'd120, 10'd60, 1'b1);
    tick();
    RST = 1'b1;
    drive_pixel(10'd121, 10'd60, 1'b1);
    tick();
    checks++; if (OUT_VALID !== 1'b0 || IN_BLOCK !== 1'b0 || HIT !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid: valid/in/hit got %b/%b/%b want 0/0/0", OUT_VALID, IN_BLOCK, HIT); end
    RST = 1'b0;
    idle();
    tick();
    checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("[TB] FAIL rst_drop: OUT_VALID got %b want 0", OUT_VALID); end
    drive_pixel(10'd120, 10'd60, 1'b0);
    tick(); idle(); tick();
    checks++; if (OUT_VALID !== 1'b1 || IN_BLOCK !== 1'b0) begin errors++; $display("[TB] FAIL rst_table: valid/in got %b/%b want 1/0", OUT_VALID, IN_BLOCK); end
  endtask

  initial begin
    RST         = 1'b1;
    PIX_VALID   = 1'b0;
    X           = '0;
    Y           = '0;
    PLAYER_MASK = 1'b0;
    FRAME_START = 1'b0;
    BLOCK_EN    = '0;
    BLOCK_X     = '0;
    BLOCK_SHAPE = '0;
    TBL_WE      = 1'b0;
    TBL_SHAPE   = '0;
    TBL_SEG     = '0;
    TBL_Y       = '0;
    TBL_LEN     = '0;
    test_reset();
    test_x_edges();
    test_priority();
    test_table_write();
    test_segments();
    test_hit();
    test_wrap();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
